// File: rtl/pp_seq_mult_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// pp_mult_pkg
//
// Purpose:
//   Shared types and constants for the partial-product multiplier family.
//   Both the parallel array and the sequential controller use this package.
//   The array produces every row at once. The controller produces one row
//   per clock.
//
// Contents:
//   state_t      - controller state encoding (IDLE, RUN, DONE)
//   WIDTH_DEF    - default operand width
//   PROD_W       - product width for the default operand width
//   IDX_W        - row index width for the default operand width
//   idx_width()  - row index width for an arbitrary operand width
// ---------------------------------------------------------------------------
package pp_mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_DEF = 8;
    localparam int PROD_W    = 2 * WIDTH_DEF;

    // A 1-bit operand still needs a 1-bit index, so the result never drops to 0.
    function automatic int idx_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    localparam int IDX_W = idx_width(WIDTH_DEF);

endpackage

// File: rtl/pp_seq_mult_ctrl_if.sv
// ---------------------------------------------------------------------------
// pp_seq_mult_ctrl_if
//
// Purpose:
//   Bundles the operand handshake, the product handshake and the status
//   outputs of the sequential multiplier controller.
//
// Signals:
//   in_valid   operand pair x/y valid                (source -> controller)
//   in_ready   controller can accept operands        (controller -> source)
//   x, y       multiplicand / multiplier, WIDTH bits (source -> controller)
//   out_valid  product valid                         (controller -> consumer)
//   out_ready  consumer accepts product              (consumer -> controller)
//   product    unsigned x*y, 2*WIDTH bits            (controller -> consumer)
//   busy       controller is in RUN or DONE
//   row_idx    index of the row being accumulated (debug)
//
// Modports:
//   slave   - the controller side
//   master  - the operand source / product consumer side
// ---------------------------------------------------------------------------
interface pp_seq_mult_ctrl_if
    import pp_mult_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF
);

    localparam int IW = idx_width(WIDTH);

    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     x;
    logic [WIDTH-1:0]     y;
    logic                 out_valid;
    logic                 out_ready;
    logic [2*WIDTH-1:0]   product;
    logic                 busy;
    logic [IW-1:0]        row_idx;

    modport slave (
        input  in_valid,
        input  x,
        input  y,
        input  out_ready,
        output in_ready,
        output out_valid,
        output product,
        output busy,
        output row_idx
    );

    modport master (
        output in_valid,
        output x,
        output y,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  product,
        input  busy,
        input  row_idx
    );

endinterface

// File: rtl/pp_seq_mult_ctrl_row_gen.sv
// ---------------------------------------------------------------------------
// pp_row_gen
//
// Purpose:
//   Combinational partial-product row generator. It passes the shifted
//   multiplicand through when the current multiplier bit is set and outputs
//   zero otherwise. The parallel array and the sequential controller both
//   use it, so their rows are bit-identical.
//
// Ports:
//   xs     input   W   shifted multiplicand (already zero padded)
//   y_bit  input   1   multiplier bit selecting this row
//   row    output  W   xs AND y_bit
// ---------------------------------------------------------------------------
module pp_row_gen #(
    parameter int W = 16
) (
    input  logic [W-1:0] xs,
    input  logic         y_bit,
    output logic [W-1:0] row
);

    assign row = xs & {W{y_bit}};

endmodule

// File: rtl/pp_seq_mult_ctrl.sv
// ---------------------------------------------------------------------------
// pp_seq_mult_ctrl
//
// Purpose:
//   Sequential partial-product multiplier controller. It accepts an operand
//   pair and then accumulates one row (x << i when y[i] is set) per clock.
//   The 2*WIDTH-bit product is returned over a valid/ready handshake. With
//   EARLY_TERM set, the run stops as soon as the remaining multiplier bits
//   are all zero.
//
// Parameters:
//   WIDTH       operand width; product is 2*WIDTH bits
//   EARLY_TERM  1 = stop once the remaining y bits are zero, 0 = WIDTH rows
//
// Ports:
//   clk    input   rising-edge clock for all state
//   rst_n  input   synchronous active-low reset
//   bus    slave   operand/product handshakes, busy and row_idx
//                  (see pp_seq_mult_ctrl_if)
// ---------------------------------------------------------------------------
module pp_seq_mult_ctrl
    import pp_mult_pkg::*;
#(
    parameter int WIDTH      = WIDTH_DEF,
    parameter bit EARLY_TERM = 1'b1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    pp_seq_mult_ctrl_if.slave    bus
);

    localparam int PW = 2 * WIDTH;
    localparam int IW = idx_width(WIDTH);

    state_t            state;
    state_t            state_next;

    logic [PW-1:0]     xs;
    logic [WIDTH-1:0]  ys;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     acc_next;
    logic [PW-1:0]     row;
    logic [PW-1:0]     product_r;
    logic [IW-1:0]     row_idx_r;
    logic              out_valid_r;
    logic              last_row;

    pp_row_gen #(
        .W (PW)
    ) u_row_gen (
        .xs    (xs),
        .y_bit (ys[0]),
        .row   (row)
    );

    // x is zero-extended into 2*WIDTH bits, so the sum of all rows is at most
    // (2^W-1)^2. The accumulator therefore can never overflow.
    assign acc_next = acc + row;

    // The row in flight is the last one when the index reaches the top bit.
    // With early termination, it is also the last one when nothing is left in
    // y after this row is consumed.
    assign last_row = (row_idx_r == IW'(WIDTH - 1)) ||
                      (EARLY_TERM && ((ys >> 1) == '0));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // in_ready comes from the state alone. DONE returns to IDLE before it can
    // accept again, so there is no same-cycle hand-off.
    always_comb begin
        state_next   = state;
        bus.in_ready = 1'b0;
        bus.busy     = 1'b0;
        unique case (state)
            IDLE: begin
                bus.in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                bus.busy = 1'b1;
                if (last_row) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                bus.busy = 1'b1;
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            xs          <= '0;
            ys          <= '0;
            acc         <= '0;
            row_idx_r   <= '0;
            product_r   <= '0;
            out_valid_r <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        xs        <= {{WIDTH{1'b0}}, bus.x};
                        ys        <= bus.y;
                        acc       <= '0;
                        row_idx_r <= '0;
                    end
                end
                RUN: begin
                    acc       <= acc_next;
                    xs        <= xs << 1;
                    ys        <= ys >> 1;
                    row_idx_r <= row_idx_r + IW'(1);
                    if (last_row) begin
                        // Register the sum that includes this cycle's row,
                        // not the stale accumulator.
                        product_r   <= acc_next;
                        out_valid_r <= 1'b1;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_r <= 1'b0;
                    end
                end
                default: begin
                    out_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.out_valid = out_valid_r;
    assign bus.product   = product_r;
    assign bus.row_idx   = row_idx_r;

endmodule
